wm_insert_pipe: RTL and testbench
=================================

Name: wm_insert_pipe

Overview:
- Parametrised, pipelined successor to the watermark insertion datapath.
- Embeds a WM_W-bit watermark symbol per pixel by mixing a selected neighbour pixel with a two-level neighbour average, using frame-latched fixed-point coefficients.
- Streams pixels with a valid/ready handshake, supports backpressure, and runs frame-bounded between a start pulse and frame_done.

Parameters:
PIX_W, 8, pixel width in bits
COEF_W, 8, coefficient width; unsigned fraction Q0.COEF_W (value/2^COEF_W)
FRAME_PIX, 4096, pixels per frame (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame and latches a1/a2
a1  in  COEF_W  weight on selected pixel
a2  in  COEF_W  weight on neighbour average
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat
d1, d2, d3, d4  in  PIX_W each  current pixel and neighbours
wm  in  2  watermark symbol for this pixel
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  PIX_W  watermarked pixel
out_last  out  1  high with the final pixel of the frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last output is accepted

Behaviour:
- Reset (rst=1 at the clock edge) clears all registers.
  - Zero after reset: busy, out_valid, out_last, frame_done, out_data, all stage-valid bits, input/output counters, coefficient registers.
  - Reset mid-frame aborts the frame; in-flight data is discarded.
  - rst has priority over every other input.
- Frame control:
  - Idle, start=1: set busy, latch a1/a2 into coefficient registers, clear counters.
  - start while busy is ignored, and the coefficients do not change.
  - in_ready = busy & (in_cnt < FRAME_PIX) & adv.
  - Accepted beat: in_valid & in_ready. Each accepted beat increments in_cnt.
  - Once FRAME_PIX beats are accepted, further input is refused until the next frame.
- Pipeline (3 stages, global advance):
  - adv = ~out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0.
  - A bubble (invalid stage) still shifts.
  - Latency: accepted beat at cycle N appears on out_valid/out_data at cycle N+3 with no stall.
  - Throughput: 1 pixel/cycle.
  - S1: register the pixels, wm, and a stage-valid bit; compute
    - h = (d1 + d2) >> 1, using a PIX_W+1-bit add
    - avg = (d3 + h) >> 1
    - sel = d1 when wm=1, d2 when wm=2, d4 when wm=3.
  - S2: p1 = a1q * sel and p2 = a2q * avg, each PIX_W+COEF_W bits; d1 carries through for wm=0.
  - S3:
    - wm=0: out_data = d1 (pass-through, no arithmetic).
    - Otherwise: s = p1 + p2 + 2^(COEF_W-1), PIX_W+COEF_W+1 bits; r = s >> COEF_W.
    - Saturate: out_data = (r > 2^PIX_W-1) ? 2^PIX_W-1 : r[PIX_W-1:0].
- Output:
  - out_data and out_last are stable while out_valid & ~out_ready.
  - out_cnt increments on each output handshake.
  - out_last = out_valid & (out_cnt == FRAME_PIX-1).
- Frame end: on the handshake of the out_last beat, the next cycle has frame_done=1 and busy=0.
  - A start in the frame_done cycle is accepted and begins a new frame.
- Simultaneous events:
  - Input acceptance and output handshake in the same cycle are both honoured.
  - start together with in_valid while idle: in_ready is still 0 that cycle; the first beat is accepted the next cycle.
- Counters are $clog2(FRAME_PIX+1) bits wide; there is no wrap within a frame.

Test Plan:
- Use PIX_W=8, COEF_W=8, FRAME_PIX=4, a1=a2=128, and pixels d1=100, d2=50, d3=30, d4=10 (avg=52).
- Mode sweep: send 4 beats with wm=0,1,2,3 -> out_data 100, 76, 51, 31 in order. Each appears 3 cycles after acceptance; out_last on the 4th beat; frame_done 1 cycle later.
- Saturation: a1=a2=255, all pixels 255, wm=1 -> r=508 -> out_data=255. Also a1=a2=0, wm=2 -> out_data=0.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and out_data frozen. On release, outputs arrive in order with none lost or duplicated.
- Frame bounds:
  - in_valid before start -> in_ready=0.
  - After 4 beats accepted, a 5th offered -> not accepted.
  - start mid-frame with a1=0 -> ignored; results still use a1=128.
- Reset mid-frame: assert rst after 2 beats with data in flight -> next cycle busy=0, out_valid=0, counters 0. A new start then runs a full 4-pixel frame.

Source files
------------

// File: rtl/wm_insert_pipe_if.sv
// Pixel stream bundle for wm_insert_pipe: one input beat channel and one output beat channel.
// A beat transfers on a rising edge where valid and ready are both high; payload is held while valid & ~ready.
interface wm_insert_pipe_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] d1;
    logic [PIX_W-1:0] d2;
    logic [PIX_W-1:0] d3;
    logic [PIX_W-1:0] d4;
    logic [1:0]       wm;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, d1, d2, d3, d4, wm, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, d1, d2, d3, d4, wm, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/wm_insert_pipe.sv
// Three-stage watermark insertion pipeline: mixes a selected neighbour with a neighbour average
// using frame-latched Q0.COEF_W weights, with global-advance backpressure and frame bounding.
module wm_insert_pipe #(
    parameter int PIX_W     = 8,
    parameter int COEF_W    = 8,
    parameter int FRAME_PIX = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COEF_W-1:0] a1,
    input  logic [COEF_W-1:0] a2,
    wm_insert_pipe_if.slave   bus,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state_o
);
    localparam int PW = PIX_W + COEF_W;
    localparam int CW = $clog2(FRAME_PIX + 1);
    localparam logic [CW-1:0] FRAME_N = CW'(FRAME_PIX);
    localparam logic [CW-1:0] LAST_N  = CW'(FRAME_PIX - 1);
    localparam logic [PW:0]   RND     = (PW + 1)'(1) << (COEF_W - 1);
    localparam logic [PW:0]   MAXV    = {{(PW + 1 - PIX_W){1'b0}}, {PIX_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   start_frame;

    logic [COEF_W-1:0] a1_q, a2_q;
    logic [CW-1:0]     in_cnt_q, out_cnt_q;

    logic             v1_q, v2_q, v3_q;
    logic [1:0]       wm1_q, wm2_q;
    logic [PIX_W-1:0] sel1_q, avg1_q, pass1_q, pass2_q, out_q;
    logic [PW-1:0]    p1_q, p2_q;

    logic             adv, in_hs, out_hs;
    logic [PIX_W:0]   h_sum, avg_sum;
    logic [PIX_W-1:0] h, avg_d, sel_d, out_d;
    logic [PW-1:0]    p1_d, p2_d;
    logic [PW:0]      s, r;

    assign adv           = ~v3_q | bus.out_ready;
    assign bus.in_ready  = busy & (in_cnt_q < FRAME_N) & adv;
    assign in_hs         = bus.in_valid & bus.in_ready;
    assign out_hs        = v3_q & bus.out_ready;
    assign bus.out_valid = v3_q;
    assign bus.out_data  = out_q;
    assign bus.out_last  = v3_q & (out_cnt_q == LAST_N);
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A start is honoured in IDLE and in the frame_done cycle, never while a frame runs.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        frame_done  = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_frame = start;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (out_hs && bus.out_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                start_frame = start;
                state_d     = start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q      <= '0;
            a2_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (start_frame) begin
            a1_q      <= a1;
            a2_q      <= a2;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (in_hs)  in_cnt_q  <= in_cnt_q + CW'(1);
            if (out_hs) out_cnt_q <= out_cnt_q + CW'(1);
        end
    end

    always_comb begin
        h_sum   = {1'b0, bus.d1} + {1'b0, bus.d2};
        h       = PIX_W'(h_sum >> 1);
        avg_sum = {1'b0, bus.d3} + {1'b0, h};
        avg_d   = PIX_W'(avg_sum >> 1);
        case (bus.wm)
            2'd1:    sel_d = bus.d1;
            2'd2:    sel_d = bus.d2;
            2'd3:    sel_d = bus.d4;
            default: sel_d = bus.d1;
        endcase
        p1_d = PW'(a1_q) * PW'(sel1_q);
        p2_d = PW'(a2_q) * PW'(avg1_q);
        s    = {1'b0, p1_q} + {1'b0, p2_q} + RND;
        r    = s >> COEF_W;
        if (wm2_q == 2'd0)  out_d = pass2_q;
        else if (r > MAXV)  out_d = {PIX_W{1'b1}};
        else                out_d = r[PIX_W-1:0];
    end

    // Every stage moves together on adv; invalid stages shift as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            wm1_q   <= '0;
            wm2_q   <= '0;
            sel1_q  <= '0;
            avg1_q  <= '0;
            pass1_q <= '0;
            pass2_q <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            out_q   <= '0;
        end else if (adv) begin
            v1_q    <= in_hs;
            wm1_q   <= bus.wm;
            sel1_q  <= sel_d;
            avg1_q  <= avg_d;
            pass1_q <= bus.d1;
            v2_q    <= v1_q;
            wm2_q   <= wm1_q;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            pass2_q <= pass1_q;
            v3_q    <= v2_q;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_wm_insert_pipe.sv
// Directed bench for wm_insert_pipe with FRAME_PIX=4: modes, saturation, backpressure, frame bounds, reset.
module tb_wm_insert_pipe;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a1, a2;
    logic       busy, frame_done;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] SWEEP_EXP [4] = '{8'd100, 8'd76, 8'd51, 8'd31};

    logic [7:0] bd1 [4];
    logic [7:0] bd2 [4];
    logic [7:0] bd3 [4];
    logic [7:0] bd4 [4];
    logic [1:0] bwm [4];
    logic [7:0] cap_data [$];
    logic       cap_last [$];
    logic       done_seen;
    logic [7:0] exp_q [$];

    wm_insert_pipe_if #(.PIX_W(8)) bus ();

    wm_insert_pipe #(.PIX_W(8), .COEF_W(8), .FRAME_PIX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a1          (a1),
        .a2          (a2),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [7:0] p1, p2, p3, p4);
        bus.d1 = p1; bus.d2 = p2; bus.d3 = p3; bus.d4 = p4;
    endtask

    task automatic load_sweep_beats();
        for (int i = 0; i < 4; i++) begin
            bd1[i] = 8'd100; bd2[i] = 8'd50; bd3[i] = 8'd30; bd4[i] = 8'd10;
            bwm[i] = 2'(i);
        end
    endtask

    // Driver: runs one full frame with no output stall and captures every output handshake.
    task automatic run_frame(input logic [7:0] a1v, input logic [7:0] a2v);
        int sent;
        cap_data.delete();
        cap_last.delete();
        done_seen     = 1'b0;
        sent          = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        a1 = a1v; a2 = a2v; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            bus.in_valid = (sent < 4);
            if (sent < 4) begin
                set_pix(bd1[sent], bd2[sent], bd3[sent], bd4[sent]);
                bus.wm = bwm[sent];
            end
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                cap_data.push_back(bus.out_data);
                cap_last.push_back(bus.out_last);
            end
            if (frame_done) done_seen = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a1 = 8'd0; a2 = 8'd0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.wm = 2'd0;
        set_pix(8'd0, 8'd0, 8'd0, 8'd0);
        tick(); tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b, required 0", frame_done); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b, required 0", bus.out_last); end
        checks++; if (bus.out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", bus.out_data); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL prestart_in_ready: got %0b, required 0", bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL prestart_in_ready2: got %0b, required 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mode_sweep();
        logic ev;
        a1 = 8'd128; a2 = 8'd128;
        set_pix(8'd100, 8'd50, 8'd30, 8'd10);
        bus.out_ready = 1'b1;
        start = 1'b1; bus.in_valid = 1'b1; bus.wm = 2'd0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sweep_start_cycle_in_ready: got %0b, required 0", bus.in_ready); end
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = (c < 6);
            bus.wm = 2'(c % 4);
            #1;
            if (c < 6) begin
                checks++;
                if (bus.in_ready !== (c < 4)) begin errors++; $display("FAIL sweep_in_ready c=%0d: got %0b, required %0b", c, bus.in_ready, (c < 4)); end
            end
            ev = (c >= 3 && c <= 6);
            checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL sweep_out_valid c=%0d: got %0b, required %0b", c, bus.out_valid, ev); end
            if (ev) begin
                checks++; if (bus.out_data !== SWEEP_EXP[c-3]) begin errors++; $display("FAIL sweep_data c=%0d: got %0d, required %0d", c, bus.out_data, SWEEP_EXP[c-3]); end
                checks++; if (bus.out_last !== (c == 6)) begin errors++; $display("FAIL sweep_last c=%0d: got %0b, required %0b", c, bus.out_last, (c == 6)); end
            end
            checks++; if (busy !== (c <= 6)) begin errors++; $display("FAIL sweep_busy c=%0d: got %0b, required %0b", c, busy, (c <= 6)); end
            checks++; if (frame_done !== (c == 7)) begin errors++; $display("FAIL sweep_frame_done c=%0d: got %0b, required %0b", c, frame_done, (c == 7)); end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL sweep_done_pulse: got %0b, required 0", frame_done); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp2 [4];
        for (int i = 0; i < 4; i++) begin
            bd1[i] = 8'd255; bd2[i] = 8'd255; bd3[i] = 8'd255; bd4[i] = 8'd255; bwm[i] = 2'd1;
        end
        run_frame(8'd255, 8'd255);
        checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL sat_hi_count: got %0d, required 4", cap_data.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== 8'd255) begin errors++; $display("FAIL sat_hi_data[%0d]: got %0d, required 255", i, cap_data[i]); end
        end
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL sat_hi_done: got %0b, required 1", done_seen); end

        load_sweep_beats();
        bwm[0] = 2'd2; bwm[1] = 2'd3; bwm[2] = 2'd0; bwm[3] = 2'd1;
        exp2[0] = 8'd0; exp2[1] = 8'd0; exp2[2] = 8'd100; exp2[3] = 8'd0;
        run_frame(8'd0, 8'd0);
        checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL sat_lo_count: got %0d, required 4", cap_data.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== exp2[i]) begin errors++; $display("FAIL sat_lo_data[%0d]: got %0d, required %0d", i, cap_data[i], exp2[i]); end
            checks++; if (cap_last[i] !== (i == 3)) begin errors++; $display("FAIL sat_lo_last[%0d]: got %0b, required %0b", i, cap_last[i], (i == 3)); end
        end
    endtask

    task automatic test_backpressure();
        int sent, got;
        logic done;
        logic [7:0] e;
        sent = 0; got = 0; done = 1'b0;
        exp_q.delete();
        set_pix(8'd100, 8'd50, 8'd30, 8'd10);
        a1 = 8'd128; a2 = 8'd128; start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        for (int c = 0; c < 40; c++) begin
            bus.out_ready = !(c >= 3 && c <= 7);
            start = (c == 5);
            a1 = (c == 5) ? 8'd0 : 8'd128;
            a2 = (c == 5) ? 8'd0 : 8'd128;
            bus.in_valid = (sent < 4);
            bus.wm = 2'(sent);
            #1;
            if (c >= 3 && c <= 7) begin
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %0b, required 0", c, bus.in_ready); end
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c=%0d: got %0b, required 1", c, bus.out_valid); end
                checks++; if (bus.out_data !== 8'd100) begin errors++; $display("FAIL bp_frozen c=%0d: got %0d, required 100", c, bus.out_data); end
            end
            if (bus.out_valid && bus.out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got data %0d, required no beat", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin errors++; $display("FAIL bp_data #%0d: got %0d, required %0d", got, bus.out_data, e); end
                end
                checks++; if (bus.out_last !== (got == 4)) begin errors++; $display("FAIL bp_last #%0d: got %0b, required %0b", got, bus.out_last, (got == 4)); end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(SWEEP_EXP[sent]);
                sent++;
            end
            if (frame_done) done = 1'b1;
            tick();
            if (done) break;
        end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; a1 = 8'd128; a2 = 8'd128;
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count: got %0d, required 4", got); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d, required 0", exp_q.size()); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %0b, required 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %0b, required 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        set_pix(8'd100, 8'd50, 8'd30, 8'd10);
        a1 = 8'd128; a2 = 8'd128; start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.wm = 2'd1; tick();
        bus.wm = 2'd2; tick();
        bus.in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b, required 0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b, required 0", bus.out_valid); end
        checks++; if (dut.in_cnt_q !== '0) begin errors++; $display("FAIL rmid_in_cnt: got %0d, required 0", dut.in_cnt_q); end
        checks++; if (dut.out_cnt_q !== '0) begin errors++; $display("FAIL rmid_out_cnt: got %0d, required 0", dut.out_cnt_q); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_flush c=%0d: got %0b, required 0", c, bus.out_valid); end
        end
        load_sweep_beats();
        run_frame(8'd128, 8'd128);
        checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL rmid_count: got %0d, required 4", cap_data.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== SWEEP_EXP[i]) begin errors++; $display("FAIL rmid_data[%0d]: got %0d, required %0d", i, cap_data[i], SWEEP_EXP[i]); end
            checks++; if (cap_last[i] !== (i == 3)) begin errors++; $display("FAIL rmid_last[%0d]: got %0b, required %0b", i, cap_last[i], (i == 3)); end
        end
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL rmid_done: got %0b, required 1", done_seen); end
    endtask

    initial begin
        test_reset();
        test_mode_sweep();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
